// File: rtl/k051962_layer_shifter.sv
// k051962 tile-layer pixel serializer: double-buffered GFX ROM word,
// fine-scroll load phase, per-tile/global X flip, masked pixel outputs.
module k051962_layer_shifter #(
  parameter int BPP   = 4,
  parameter int COL_W = 8
) (
  input  logic             clk_24M,
  input  logic             nRES,
  input  logic             CE_PIX,
  input  logic [2:0]       PX_PHASE,
  input  logic [8*BPP-1:0] ROM_D,
  input  logic             ROM_LATCH,
  input  logic [COL_W-1:0] COL,
  input  logic [2:0]       FINE,
  input  logic             FLIPX_EN,
  input  logic             FLIP_SCREEN,
  input  logic             BLANK,
  input  logic             UNDERRUN_CLR,
  output logic [BPP-1:0]   PIX,
  output logic [3:0]       PAL,
  output logic             OPAQUE,
  output logic             UNDERRUN
);

  localparam int W = 8 * BPP;

  logic [W-1:0]     ld_q, ld_d;
  logic [COL_W-1:0] lcol_q, lcol_d;
  logic             lflip_q, lflip_d;
  logic             lfull_q, lfull_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [COL_W-1:0] scol_q, scol_d;
  logic [BPP-1:0]   pix_q, pix_d;
  logic [3:0]       pal_q, pal_d;
  logic             opq_q, opq_d;
  logic             und_q, und_d;

  logic [W-1:0]     ld_rev;
  logic [BPP-1:0]   top;
  logic             xfer;
  logic             und_set;

  assign top  = sh_q[W-1 -: BPP];
  assign xfer = CE_PIX && (PX_PHASE == FINE);

  // Mirror the tile: pixel i takes the slot of pixel 7-i.
  always_comb begin
    ld_rev = '0;
    for (int i = 0; i < 8; i++) begin
      ld_rev[W-1-BPP*i -: BPP] = ld_q[BPP*i+BPP-1 -: BPP];
    end
  end

  always_comb begin
    ld_d    = ld_q;
    lcol_d  = lcol_q;
    lflip_d = lflip_q;
    lfull_d = lfull_q;
    sh_d    = sh_q;
    scol_d  = scol_q;
    pix_d   = pix_q;
    pal_d   = pal_q;
    opq_d   = opq_q;
    und_set = 1'b0;
    if (CE_PIX) begin
      if (xfer) begin
        if (lfull_q) begin
          sh_d   = lflip_q ? ld_rev : ld_q;
          scol_d = lcol_q;
        end else begin
          sh_d    = '0;
          scol_d  = '0;
          und_set = 1'b1;
        end
        lfull_d = 1'b0;
      end else begin
        sh_d = sh_q << BPP;
      end
      // Latch after transfer so a coincident load refills the buffer.
      if (ROM_LATCH) begin
        ld_d    = ROM_D;
        lcol_d  = COL;
        lflip_d = (FLIPX_EN & COL[0]) ^ FLIP_SCREEN;
        lfull_d = 1'b1;
      end
      pix_d = BLANK ? '0 : top;
      pal_d = BLANK ? 4'h0 : scol_q[COL_W-1 -: 4];
      opq_d = ~BLANK & (|top);
    end
    if (und_set) und_d = 1'b1;
    else if (UNDERRUN_CLR) und_d = 1'b0;
    else und_d = und_q;
  end

  always_ff @(posedge clk_24M) begin
    if (!nRES) begin
      ld_q    <= '0;
      lcol_q  <= '0;
      lflip_q <= 1'b0;
      lfull_q <= 1'b0;
      sh_q    <= '0;
      scol_q  <= '0;
      pix_q   <= '0;
      pal_q   <= '0;
      opq_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      ld_q    <= ld_d;
      lcol_q  <= lcol_d;
      lflip_q <= lflip_d;
      lfull_q <= lfull_d;
      sh_q    <= sh_d;
      scol_q  <= scol_d;
      pix_q   <= pix_d;
      pal_q   <= pal_d;
      opq_q   <= opq_d;
      und_q   <= und_d;
    end
  end

  assign PIX      = pix_q;
  assign PAL      = pal_q;
  assign OPAQUE   = opq_q;
  assign UNDERRUN = und_q;

endmodule

// File: tb/tb_k051962_layer_shifter.sv
// Scoreboard bench for k051962_layer_shifter: directed tiles with
// hand-computed pixel streams, checked by an independent monitor.
module tb_k051962_layer_shifter;

  logic        clk_24M = 1'b0;
  logic        nRES = 1'b0;
  logic        CE_PIX = 1'b0;
  logic [2:0]  PX_PHASE = '0;
  logic [31:0] ROM_D = '0;
  logic        ROM_LATCH = 1'b0;
  logic [7:0]  COL = '0;
  logic [2:0]  FINE = '0;
  logic        FLIPX_EN = 1'b0;
  logic        FLIP_SCREEN = 1'b0;
  logic        BLANK = 1'b0;
  logic        UNDERRUN_CLR = 1'b0;
  logic [3:0]  PIX;
  logic [3:0]  PAL;
  logic        OPAQUE;
  logic        UNDERRUN;

  k051962_layer_shifter #(.BPP(4), .COL_W(8)) dut (
    .clk_24M(clk_24M), .nRES(nRES), .CE_PIX(CE_PIX),
    .PX_PHASE(PX_PHASE), .ROM_D(ROM_D), .ROM_LATCH(ROM_LATCH),
    .COL(COL), .FINE(FINE), .FLIPX_EN(FLIPX_EN),
    .FLIP_SCREEN(FLIP_SCREEN), .BLANK(BLANK),
    .UNDERRUN_CLR(UNDERRUN_CLR), .PIX(PIX), .PAL(PAL),
    .OPAQUE(OPAQUE), .UNDERRUN(UNDERRUN)
  );

  always #5 clk_24M = ~clk_24M;

  typedef struct {
    logic [3:0] pix;
    logic [3:0] pal;
    logic       opq;
    logic       und;
    int         tag;
  } exp_t;

  exp_t exq[$];
  int   passed = 0;
  int   total  = 0;
  logic ce_d = 1'b0;

  task automatic chk(input string nm, input int tag,
                     input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s step%0d: got %h want %h", nm, tag, got, want);
  endtask

  always @(posedge clk_24M) ce_d <= CE_PIX && nRES;

  always @(negedge clk_24M) begin
    if (ce_d) begin
      if (exq.size() == 0) begin
        total++;
        $display("FAIL scoreboard: got output with empty queue want entry");
      end else begin
        exp_t e;
        e = exq.pop_front();
        chk("pix", e.tag, PIX, e.pix);
        chk("pal", e.tag, PAL, e.pal);
        chk("opaque", e.tag, {3'b0, OPAQUE}, {3'b0, e.opq});
        chk("underrun", e.tag, {3'b0, UNDERRUN}, {3'b0, e.und});
      end
    end
  end

  int stepn = 0;

  task automatic tile(input logic [2:0] fine, input int lph,
                      input logic [31:0] rom, input logic [7:0] col,
                      input logic fe, input logic fs, input logic clr,
                      input logic [7:0] bmask,
                      input logic [31:0] epix, input logic [31:0] epal,
                      input logic [7:0] eopq, input logic [7:0] eund);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      @(negedge clk_24M);
      PX_PHASE     = i[2:0];
      FINE         = fine;
      ROM_LATCH    = (i == lph);
      ROM_D        = rom;
      COL          = col;
      FLIPX_EN     = fe;
      FLIP_SCREEN  = fs;
      BLANK        = bmask[7-i];
      UNDERRUN_CLR = clr;
      CE_PIX       = 1'b1;
      e.pix = epix[31-4*i -: 4];
      e.pal = epal[31-4*i -: 4];
      e.opq = eopq[7-i];
      e.und = eund[7-i];
      e.tag = stepn;
      exq.push_back(e);
      stepn++;
      @(negedge clk_24M);
      CE_PIX       = 1'b0;
      ROM_LATCH    = 1'b0;
      UNDERRUN_CLR = 1'b0;
      repeat (2) @(negedge clk_24M);
    end
  endtask

  initial begin
    CE_PIX = 1'b1;
    ROM_LATCH = 1'b1;
    ROM_D = 32'hFFFFFFFF;
    COL = 8'hFF;
    repeat (2) @(posedge clk_24M);
    @(negedge clk_24M);
    chk("rst_pix", -1, PIX, 4'h0);
    chk("rst_pal", -1, PAL, 4'h0);
    chk("rst_opaque", -1, {3'b0, OPAQUE}, 4'h0);
    chk("rst_underrun", -1, {3'b0, UNDERRUN}, 4'h0);
    CE_PIX = 1'b0;
    ROM_LATCH = 1'b0;
    nRES = 1'b1;
    @(negedge clk_24M);

    // Empty latch after reset: underrun at phase 0, shifter zeroed.
    tile(3'd0, 6, 32'h12345678, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00,
         32'h00000000, 32'h00000000, 8'h00, 8'hFF);
    @(negedge clk_24M);
    UNDERRUN_CLR = 1'b1;
    @(negedge clk_24M);
    UNDERRUN_CLR = 1'b0;
    chk("clr_idle", -2, {3'b0, UNDERRUN}, 4'h0);

    tile(3'd0, 6, 32'h12345678, 8'hA0, 1'b0, 1'b0, 1'b0, 8'h00,
         32'h01234567, 32'h0AAAAAAA, 8'h7F, 8'h00);
    tile(3'd3, 6, 32'h12345678, 8'hA1, 1'b1, 1'b0, 1'b0, 8'h00,
         32'h80001234, 32'hAAAAAAAA, 8'h8F, 8'h00);
    tile(3'd3, 6, 32'h12345678, 8'h51, 1'b1, 1'b1, 1'b0, 8'h00,
         32'h56788765, 32'hAAAAAAAA, 8'hFF, 8'h00);
    tile(3'd3, 6, 32'h9ABCDEF0, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00,
         32'h43211234, 32'hAAAA5555, 8'hFF, 8'h00);
    // Latch coincident with transfer, blank on phases 5 and 6.
    tile(3'd3, 3, 32'h11111111, 8'h70, 1'b0, 1'b0, 1'b0, 8'h06,
         32'h5678900C, 32'h55553003, 8'hF9, 8'h00);
    tile(3'd3, 8, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00,
         32'hDEF01111, 32'h33337777, 8'hEF, 8'h00);
    tile(3'd3, 8, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00,
         32'h11110000, 32'h77770000, 8'hF0, 8'h1F);
    // Clear held on every pixel: set beats clear at the transfer.
    tile(3'd3, 8, 32'h00000000, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00,
         32'h00000000, 32'h00000000, 8'h00, 8'h10);

    for (int k = 0; k < 100 && exq.size() > 0; k++) @(negedge clk_24M);
    if (exq.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", exq.size());
    end
    repeat (4) @(negedge clk_24M);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
